// File: rtl/arbitro_i2c.sv
// Round-robin arbiter that shares one I2C transaction generator between two requesters.
// Optional macro ARB_I2C_TIMEOUT_EN: abort stalled transactions with an ERR pulse.
module arbitro_i2c #(
  parameter int IDLE_CYC    = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        REQ0_VALID,
  input  logic        REQ0_RNW,
  input  logic [6:0]  REQ0_ADDR,
  input  logic [15:0] REQ0_WDATA,
  output logic        REQ0_ACK,
  output logic        REQ0_DONE,
  output logic [15:0] REQ0_RDATA,
  input  logic        REQ1_VALID,
  input  logic        REQ1_RNW,
  input  logic [6:0]  REQ1_ADDR,
  input  logic [15:0] REQ1_WDATA,
  output logic        REQ1_ACK,
  output logic        REQ1_DONE,
  output logic [15:0] REQ1_RDATA,
  output logic        ERR,
  output logic        BUSY,
  output logic        START_STB,
  output logic        RNW,
  output logic [6:0]  I2C_ADDR,
  output logic [15:0] WR_DATA,
  input  logic        SCL,
  input  logic [15:0] RD_DATA,
  output logic [2:0]  dbg_state
);

  // Handshake: REQx_VALID is a level held by the requester until it sees the one-cycle
  // REQx_ACK pulse, then dropped; a VALID still high when the arbiter is idle is a new request.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_ACT  = 3'd2,
    S_WAIT_IDLE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam int CNT_NEED = (IDLE_CYC > TIMEOUT_CYC) ? IDLE_CYC : TIMEOUT_CYC;

  generate
    if (IDLE_CYC < 2 || CNT_NEED > (2 ** CNT_W) - 1) begin : g_bad_params
      $error("arbitro_i2c: IDLE_CYC must be >= 2 and CNT_W wide enough for the cycle limits");
    end
  endgenerate

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

`ifdef ARB_I2C_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam int               DW_W      = CNT_W + 5;
  localparam logic [DW_W-1:0]  DWELL_LIM = DW_W'(16 * TIMEOUT_CYC);
`endif

  state_t           state;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             grant1;

`ifdef ARB_I2C_TIMEOUT_EN
  logic [DW_W-1:0]  dwell;
  logic             abort_q;
`else
  assign ERR = 1'b0;
`endif

  assign dbg_state = state;
  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  // On a tie the channel that did not win last time is served.
  assign grant1    = REQ1_VALID && (!REQ0_VALID || !last_grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      REQ0_ACK   <= 1'b0;
      REQ1_ACK   <= 1'b0;
      REQ0_DONE  <= 1'b0;
      REQ1_DONE  <= 1'b0;
      REQ0_RDATA <= '0;
      REQ1_RDATA <= '0;
      BUSY       <= 1'b0;
      START_STB  <= 1'b0;
      RNW        <= 1'b0;
      I2C_ADDR   <= '0;
      WR_DATA    <= '0;
`ifdef ARB_I2C_TIMEOUT_EN
      ERR        <= 1'b0;
      dwell      <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
      REQ0_ACK  <= 1'b0;
      REQ1_ACK  <= 1'b0;
      REQ0_DONE <= 1'b0;
      REQ1_DONE <= 1'b0;
      START_STB <= 1'b0;
`ifdef ARB_I2C_TIMEOUT_EN
      ERR       <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (REQ0_VALID || REQ1_VALID) begin
            if (grant1) begin
              RNW      <= REQ1_RNW;
              I2C_ADDR <= REQ1_ADDR;
              WR_DATA  <= REQ1_WDATA;
              REQ1_ACK <= 1'b1;
            end else begin
              RNW      <= REQ0_RNW;
              I2C_ADDR <= REQ0_ADDR;
              WR_DATA  <= REQ0_WDATA;
              REQ0_ACK <= 1'b1;
            end
            owner      <= grant1;
            last_grant <= grant1;
            BUSY       <= 1'b1;
            state      <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          START_STB <= 1'b1;
          cnt       <= '0;
`ifdef ARB_I2C_TIMEOUT_EN
          dwell     <= '0;
`endif
          state     <= S_WAIT_ACT;
        end

        S_WAIT_ACT: begin
          if (!SCL) begin
            cnt   <= '0;
            state <= S_WAIT_IDLE;
          end
`ifdef ARB_I2C_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            abort_q <= 1'b1;
            state   <= S_DONE;
          end
`endif
          else begin
            cnt <= cnt_inc;
          end
        end

        // End of transaction: SCL sampled high IDLE_CYC cycles in a row.
        S_WAIT_IDLE: begin
`ifdef ARB_I2C_TIMEOUT_EN
          dwell <= dwell + 1'b1;
          if (dwell >= DWELL_LIM) begin
            abort_q <= 1'b1;
            state   <= S_DONE;
          end else
`endif
          if (SCL) begin
            if (cnt == IDLE_LAST) begin
              state <= S_DONE;
            end else begin
              cnt <= cnt_inc;
            end
          end else begin
            cnt <= '0;
          end
        end

        S_DONE: begin
          if (owner) begin
            REQ1_DONE <= 1'b1;
          end else begin
            REQ0_DONE <= 1'b1;
          end
`ifdef ARB_I2C_TIMEOUT_EN
          ERR     <= abort_q;
          abort_q <= 1'b0;
          if (RNW && !abort_q) begin
`else
          if (RNW) begin
`endif
            if (owner) begin
              REQ1_RDATA <= RD_DATA;
            end else begin
              REQ0_RDATA <= RD_DATA;
            end
          end
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_i2c.sv
// Self-checking bench for arbitro_i2c: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model.
module tb_arbitro_i2c;
  localparam int IDLE_CYC    = 8;
  localparam int TIMEOUT_CYC = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        REQ0_VALID, REQ0_RNW, REQ1_VALID, REQ1_RNW;
  logic [6:0]  REQ0_ADDR, REQ1_ADDR;
  logic [15:0] REQ0_WDATA, REQ1_WDATA;
  logic        REQ0_ACK, REQ0_DONE, REQ1_ACK, REQ1_DONE;
  logic [15:0] REQ0_RDATA, REQ1_RDATA;
  logic        ERR, BUSY, START_STB, RNW, SCL;
  logic [6:0]  I2C_ADDR;
  logic [15:0] WR_DATA, RD_DATA;
  logic [2:0]  dbg_state;

  arbitro_i2c #(.IDLE_CYC(IDLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .REQ0_VALID(REQ0_VALID), .REQ0_RNW(REQ0_RNW), .REQ0_ADDR(REQ0_ADDR),
    .REQ0_WDATA(REQ0_WDATA), .REQ0_ACK(REQ0_ACK), .REQ0_DONE(REQ0_DONE),
    .REQ0_RDATA(REQ0_RDATA),
    .REQ1_VALID(REQ1_VALID), .REQ1_RNW(REQ1_RNW), .REQ1_ADDR(REQ1_ADDR),
    .REQ1_WDATA(REQ1_WDATA), .REQ1_ACK(REQ1_ACK), .REQ1_DONE(REQ1_DONE),
    .REQ1_RDATA(REQ1_RDATA),
    .ERR(ERR), .BUSY(BUSY), .START_STB(START_STB), .RNW(RNW),
    .I2C_ADDR(I2C_ADDR), .WR_DATA(WR_DATA), .SCL(SCL), .RD_DATA(RD_DATA),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / pulse monitor ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_stb = 0, n_ack0 = 0, n_ack1 = 0, n_done0 = 0, n_done1 = 0;

  // Outputs sampled at posedge see the value held during the previous cycle.
  always @(posedge clk) begin
    if (START_STB) n_stb++;
    if (REQ0_ACK)  n_ack0++;
    if (REQ1_ACK)  n_ack1++;
    if (REQ0_DONE) n_done0++;
    if (REQ1_DONE) n_done1++;
  end

  // ---------------- reference model / scoreboard ----------------
  int          m_last;
  logic [15:0] m_rdata [2];
  logic [16:0] exp_q[$];

  function automatic int m_pick(input bit v0, input bit v1);
    if (v0 && v1) return (m_last == 1) ? 0 : 1;
    return v0 ? 0 : 1;
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b0;
    REQ0_VALID = 0; REQ0_RNW = 0; REQ0_ADDR = '0; REQ0_WDATA = '0;
    REQ1_VALID = 0; REQ1_RNW = 0; REQ1_ADDR = '0; REQ1_WDATA = '0;
    SCL = 1'b1; RD_DATA = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_last = 1; m_rdata[0] = '0; m_rdata[1] = '0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic set_req(input int ch, input bit rnw, input logic [6:0] a, input logic [15:0] d);
    if (ch == 0) begin
      REQ0_RNW = rnw; REQ0_ADDR = a; REQ0_WDATA = d; REQ0_VALID = 1'b1;
    end else begin
      REQ1_RNW = rnw; REQ1_ADDR = a; REQ1_WDATA = d; REQ1_VALID = 1'b1;
    end
  endtask

  task automatic wait_ack(input bit keep, output int ch, output int lat);
    ch = -1; lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (REQ0_ACK || REQ1_ACK) begin
        ch = (REQ0_ACK && REQ1_ACK) ? 2 : (REQ1_ACK ? 1 : 0);
        lat = i;
        if (!keep) begin
          if (REQ0_ACK) REQ0_VALID = 1'b0;
          if (REQ1_ACK) REQ1_VALID = 1'b0;
        end
        break;
      end
    end
  endtask

  task automatic tick(input logic [23:0] cap, input bit tog, inout bit hb);
    @(negedge clk);
    if ({RNW, I2C_ADDR, WR_DATA} !== cap) hb = 1'b1;
    if (tog) REQ1_VALID = 1'($urandom_range(0, 1));
  endtask

  // Generator stand-in: a few SCL low/high pulses, high phases shorter than IDLE_CYC.
  task automatic drive_scl(input int pulses, input logic [23:0] cap, input bit tog, inout bit hb);
    repeat ($urandom_range(1, 3)) tick(cap, tog, hb);
    for (int p = 0; p < pulses; p++) begin
      SCL = 1'b0;
      repeat ($urandom_range(1, 3)) tick(cap, tog, hb);
      SCL = 1'b1;
      if (p != pulses - 1) repeat ($urandom_range(1, IDLE_CYC - 2)) tick(cap, tog, hb);
    end
    if (tog) REQ1_VALID = 1'b1;
  endtask

  task automatic finish_txn(input int pulses, input logic [15:0] rdv, input bit tog,
                            output bit stb_ok, output int done_ch, output int lat,
                            output bit hb, output bit err_seen);
    logic [23:0] cap;
    @(negedge clk);
    stb_ok = START_STB;
    RD_DATA = rdv;
    cap = {RNW, I2C_ADDR, WR_DATA};
    hb = 1'b0;
    drive_scl(pulses, cap, tog, hb);
    done_ch = -1; lat = -1; err_seen = 1'b0;
    for (int i = 1; i <= 4 * IDLE_CYC; i++) begin
      @(negedge clk);
      if ({RNW, I2C_ADDR, WR_DATA} !== cap) hb = 1'b1;
      if (REQ0_DONE || REQ1_DONE) begin
        done_ch = REQ1_DONE ? 1 : 0;
        lat = i;
        err_seen = ERR;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({REQ0_ACK, REQ1_ACK, REQ0_DONE, REQ1_DONE, ERR, BUSY, START_STB} !== 7'b0) begin
      failures++;
      $display("FAIL reset_pulses: got %b expected 0", {REQ0_ACK, REQ1_ACK, REQ0_DONE, REQ1_DONE, ERR, BUSY, START_STB});
    end
    do_reset();
    checks++;
    if ({RNW, I2C_ADDR, WR_DATA, REQ0_RDATA, REQ1_RDATA} !== 56'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: got %h busy=%b expected 0", {RNW, I2C_ADDR, WR_DATA, REQ0_RDATA, REQ1_RDATA}, BUSY);
    end
  endtask

  task automatic test_single_write();
    int ch, alat, dch, lat, s0, d0, d1;
    bit stb_ok, hb, err;
    s0 = n_stb; d0 = n_done0; d1 = n_done1;
    set_req(0, 1'b0, 7'h2A, 16'hBEEF);
    m_last = m_pick(1'b1, 1'b0);
    wait_ack(1'b0, ch, alat);
    checks++;
    if (ch !== 0 || alat !== 1) begin
      failures++; $display("FAIL write_ack: got ch=%0d lat=%0d expected ch=0 lat=1", ch, alat);
    end
    finish_txn(3, 16'hA5A5, 1'b0, stb_ok, dch, lat, hb, err);
    checks++;
    if (stb_ok !== 1'b1) begin failures++; $display("FAIL write_stb: got %b expected 1", stb_ok); end
    checks++;
    if ({RNW, I2C_ADDR, WR_DATA} !== {1'b0, 7'h2A, 16'hBEEF} || hb !== 1'b0) begin
      failures++; $display("FAIL write_gen_inputs: got %h hold_bad=%b expected 02abeef", {RNW, I2C_ADDR, WR_DATA}, hb);
    end
    checks++;
    if (dch !== 0 || lat !== IDLE_CYC + 1 || err !== 1'b0) begin
      failures++; $display("FAIL write_done: got ch=%0d lat=%0d err=%b expected ch=0 lat=%0d err=0", dch, lat, err, IDLE_CYC + 1);
    end
    checks++;
    if (REQ0_RDATA !== m_rdata[0]) begin
      failures++; $display("FAIL write_rdata_kept: got %h expected %h", REQ0_RDATA, m_rdata[0]);
    end
    @(negedge clk);
    checks++;
    if (n_stb - s0 !== 1 || n_done0 - d0 !== 1 || n_done1 - d1 !== 0) begin
      failures++; $display("FAIL write_pulse_counts: got stb=%0d done0=%0d done1=%0d expected 1 1 0", n_stb - s0, n_done0 - d0, n_done1 - d1);
    end
  endtask

  task automatic test_read();
    int ch, alat, dch, lat;
    bit stb_ok, hb, err;
    set_req(1, 1'b1, 7'h15, 16'($urandom));
    m_last = m_pick(1'b0, 1'b1);
    wait_ack(1'b0, ch, alat);
    finish_txn(2, 16'h1234, 1'b0, stb_ok, dch, lat, hb, err);
    m_rdata[1] = 16'h1234;
    checks++;
    if (ch !== 1 || dch !== 1 || stb_ok !== 1'b1 || RNW !== 1'b1 || I2C_ADDR !== 7'h15) begin
      failures++; $display("FAIL read_route: got ack=%0d done=%0d stb=%b rnw=%b addr=%h expected 1 1 1 1 15", ch, dch, stb_ok, RNW, I2C_ADDR);
    end
    checks++;
    if (REQ1_RDATA !== m_rdata[1] || REQ0_RDATA !== m_rdata[0]) begin
      failures++; $display("FAIL read_rdata: got r1=%h r0=%h expected r1=%h r0=%h", REQ1_RDATA, REQ0_RDATA, m_rdata[1], m_rdata[0]);
    end
  endtask

  task automatic test_contention();
    int ch, alat, dch, lat, exp_ch;
    bit stb_ok, hb, err;
    logic [15:0] rdv;
    do_reset();
    set_req(0, 1'b1, 7'h11, 16'h0);
    set_req(1, 1'b1, 7'h22, 16'h0);
    for (int k = 0; k < 4; k++) begin
      exp_ch = m_pick(REQ0_VALID, REQ1_VALID);
      m_last = exp_ch;
      wait_ack(k < 2, ch, alat);
      rdv = 16'($urandom);
      finish_txn($urandom_range(1, 3), rdv, 1'b0, stb_ok, dch, lat, hb, err);
      m_rdata[exp_ch] = rdv;
      checks++;
      if (ch !== exp_ch || dch !== exp_ch) begin
        failures++; $display("FAIL contention_order_%0d: got ack=%0d done=%0d expected %0d", k, ch, dch, exp_ch);
      end
      checks++;
      if (REQ0_RDATA !== m_rdata[0] || REQ1_RDATA !== m_rdata[1]) begin
        failures++; $display("FAIL contention_rdata_%0d: got %h %h expected %h %h", k, REQ0_RDATA, REQ1_RDATA, m_rdata[0], m_rdata[1]);
      end
    end
  endtask

  task automatic test_busy_request();
    int ch, alat, dch, lat, a1, s0;
    bit stb_ok, hb, err;
    s0 = n_stb; a1 = n_ack1;
    REQ1_RNW = 1'b1; REQ1_ADDR = 7'h4C; REQ1_WDATA = 16'h0;
    set_req(0, 1'b0, 7'h31, 16'h5A5A);
    m_last = m_pick(1'b1, 1'b0);
    wait_ack(1'b0, ch, alat);
    finish_txn(3, 16'h0, 1'b1, stb_ok, dch, lat, hb, err);
    checks++;
    if (dch !== 0 || n_ack1 - a1 !== 0) begin
      failures++; $display("FAIL busy_no_ack: got done_ch=%0d ack1_count=%0d expected 0 0", dch, n_ack1 - a1);
    end
    m_last = m_pick(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (REQ1_ACK !== 1'b1) begin
      failures++; $display("FAIL busy_ack_after_done: got %b expected 1", REQ1_ACK);
    end
    REQ1_VALID = 1'b0;
    finish_txn(2, 16'hC0DE, 1'b0, stb_ok, dch, lat, hb, err);
    m_rdata[1] = 16'hC0DE;
    @(negedge clk);
    checks++;
    if (dch !== 1 || REQ1_RDATA !== m_rdata[1] || n_stb - s0 !== 2) begin
      failures++; $display("FAIL busy_second_txn: got ch=%0d rdata=%h stb=%0d expected 1 %h 2", dch, REQ1_RDATA, n_stb - s0, m_rdata[1]);
    end
  endtask

  task automatic test_timeout();
    int ch, alat;
    set_req(0, 1'b1, 7'h08, 16'h0);
    SCL = 1'b1;
    m_last = m_pick(1'b1, 1'b0);
    wait_ack(1'b0, ch, alat);
    @(negedge clk);
    checks++;
    if (START_STB !== 1'b1) begin failures++; $display("FAIL timeout_stb: got %b expected 1", START_STB); end
`ifdef ARB_I2C_TIMEOUT_EN
    begin
      int lat;
      bit err;
      lat = -1; err = 1'b0;
      for (int i = 1; i <= TIMEOUT_CYC + 10; i++) begin
        @(negedge clk);
        if (REQ0_DONE) begin lat = i; err = ERR; break; end
      end
      checks++;
      if (lat !== TIMEOUT_CYC + 1 || err !== 1'b1 || REQ0_RDATA !== m_rdata[0]) begin
        failures++; $display("FAIL timeout_abort: got lat=%0d err=%b rdata=%h expected %0d 1 %h", lat, err, REQ0_RDATA, TIMEOUT_CYC + 1, m_rdata[0]);
      end
    end
`else
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 150; i++) begin
        @(negedge clk);
        if (!BUSY || REQ0_DONE || ERR) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL no_timeout_busy: got %0d bad cycles expected 0", bad); end
    end
`endif
    do_reset();
  endtask

  task automatic test_reset_mid();
    int ch, alat, dch, lat, d0;
    bit stb_ok, hb, err;
    logic [15:0] rdv;
    rdv = 16'($urandom_range(1, 65535));
    set_req(1, 1'b1, 7'h19, 16'h0);
    m_last = m_pick(1'b0, 1'b1);
    wait_ack(1'b0, ch, alat);
    finish_txn(2, rdv, 1'b0, stb_ok, dch, lat, hb, err);
    m_rdata[1] = rdv;
    set_req(0, 1'b1, 7'h33, 16'h7777);
    wait_ack(1'b0, ch, alat);
    @(negedge clk);
    SCL = 1'b0;
    repeat (2) @(negedge clk);
    SCL = 1'b1;
    repeat (3) @(negedge clk);
    d0 = n_done0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({REQ0_ACK, REQ1_ACK, REQ0_DONE, REQ1_DONE, ERR, BUSY, START_STB, RNW, I2C_ADDR, WR_DATA, REQ0_RDATA, REQ1_RDATA} !== '0) begin
      failures++; $display("FAIL mid_reset_async: got busy=%b addr=%h r1=%h expected all zero", BUSY, I2C_ADDR, REQ1_RDATA);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_last = 1; m_rdata[0] = '0; m_rdata[1] = '0;
    repeat (IDLE_CYC + 4) @(negedge clk);
    checks++;
    if (n_done0 - d0 !== 0 || BUSY !== 1'b0) begin
      failures++; $display("FAIL mid_reset_lost: got done0=%0d busy=%b expected 0 0", n_done0 - d0, BUSY);
    end
    rdv = 16'($urandom);
    set_req(1, 1'b1, 7'h44, 16'h0);
    m_last = m_pick(1'b0, 1'b1);
    wait_ack(1'b0, ch, alat);
    finish_txn(2, rdv, 1'b0, stb_ok, dch, lat, hb, err);
    m_rdata[1] = rdv;
    checks++;
    if (ch !== 1 || dch !== 1 || lat !== IDLE_CYC + 1 || REQ1_RDATA !== m_rdata[1]) begin
      failures++; $display("FAIL mid_reset_recover: got ch=%0d/%0d lat=%0d rdata=%h expected 1/1 %0d %h", ch, dch, lat, REQ1_RDATA, IDLE_CYC + 1, m_rdata[1]);
    end
  endtask

  task automatic test_random();
    int ch, alat, dch, lat, exp_ch;
    bit stb_ok, hb, err, v0, v1;
    logic [15:0] rdv;
    logic [16:0] e;
    do_reset();
    for (int it = 0; it < 12; it++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v0) set_req(0, 1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom));
      if (v1) set_req(1, 1'($urandom_range(0, 1)), 7'($urandom), 16'($urandom));
      while (REQ0_VALID || REQ1_VALID) begin
        exp_ch = m_pick(REQ0_VALID, REQ1_VALID);
        m_last = exp_ch;
        if ((exp_ch == 0) ? REQ0_RNW : REQ1_RNW) m_rdata[exp_ch] = 16'($urandom);
        rdv = m_rdata[exp_ch];
        exp_q.push_back({1'(exp_ch), m_rdata[exp_ch]});
        wait_ack(1'b0, ch, alat);
        if (ch < 0) begin REQ0_VALID = 1'b0; REQ1_VALID = 1'b0; end
        finish_txn($urandom_range(1, 4), (rdv == m_rdata[exp_ch]) ? rdv : 16'h0, 1'b0, stb_ok, dch, lat, hb, err);
        e = exp_q.pop_front();
        checks++;
        if (ch !== int'(e[16]) || dch !== int'(e[16]) || lat !== IDLE_CYC + 1 || hb !== 1'b0) begin
          failures++; $display("FAIL random_txn_%0d: got ack=%0d done=%0d lat=%0d hold_bad=%b expected ch=%0d lat=%0d", it, ch, dch, lat, hb, e[16], IDLE_CYC + 1);
        end
        checks++;
        if ((e[16] ? REQ1_RDATA : REQ0_RDATA) !== e[15:0] || REQ0_RDATA !== m_rdata[0] || REQ1_RDATA !== m_rdata[1]) begin
          failures++; $display("FAIL random_rdata_%0d: got %h %h expected %h %h", it, REQ0_RDATA, REQ1_RDATA, m_rdata[0], m_rdata[1]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_single_write();
    test_read();
    test_contention();
    test_busy_request();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
